// File: rtl/display_scan_driver_if.sv
// Connection between the display scan driver and the surrounding time datapath / pins.
// The driver (master) issues the digit selector and receives the muxed digit back.
interface display_scan_driver_if;
    logic       enable;
    logic       lz_blank;
    logic [3:0] time_digit;
    logic [3:0] selector;
    logic [3:0] anodes;
    logic [6:0] segments;
    logic       frame_tick;

    modport master (
        input  enable,
        input  lz_blank,
        input  time_digit,
        output selector,
        output anodes,
        output segments,
        output frame_tick
    );

    modport slave (
        output enable,
        output lz_blank,
        output time_digit,
        input  selector,
        input  anodes,
        input  segments,
        input  frame_tick
    );
endinterface

// File: rtl/display_scan_driver.sv
// 4-digit multiplexed seven-segment scan driver with per-slot dead-time blanking,
// leading-zero suppression on the minutes-tens digit and a frame-start pulse.
module display_scan_driver #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    display_scan_driver_if.master scan
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);
    localparam logic [3:0]    SEL_FIRST = 4'b0001;
    localparam logic [3:0]    SEL_MIN_TENS = 4'b1000;

    logic [CW-1:0] cnt;
    logic [3:0]    selector_q;
    logic [3:0]    anodes_q;
    logic [6:0]    segments_q;
    logic          frame_tick_q;

    logic          slot_end;
    logic          dark;
    logic [6:0]    seg_decoded;

    assign slot_end = (cnt == LAST_CNT);

    // The digit under the current selector is either in its dead-time window,
    // suppressed as a leading zero, or the whole scan is disabled.
    assign dark = !scan.enable
               || (cnt < BLANK_CNT)
               || (scan.lz_blank && (selector_q == SEL_MIN_TENS) && (scan.time_digit == 4'd0));

    // NOTE: every output of this block gets a value before the case, so no latch is inferred.
    always_comb begin
        seg_decoded = 7'h7F;
        case (scan.time_digit)
            4'd0:    seg_decoded = 7'h40;
            4'd1:    seg_decoded = 7'h79;
            4'd2:    seg_decoded = 7'h24;
            4'd3:    seg_decoded = 7'h30;
            4'd4:    seg_decoded = 7'h19;
            4'd5:    seg_decoded = 7'h12;
            4'd6:    seg_decoded = 7'h02;
            4'd7:    seg_decoded = 7'h78;
            4'd8:    seg_decoded = 7'h00;
            4'd9:    seg_decoded = 7'h10;
            default: seg_decoded = 7'h7F;
        endcase
    end

    // NOTE: registers use <= so every term above is sampled with its pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            selector_q   <= SEL_FIRST;
            anodes_q     <= 4'hF;
            segments_q   <= 7'h7F;
            frame_tick_q <= 1'b0;
        end else begin
            if (scan.enable) begin
                if (slot_end) begin
                    cnt        <= '0;
                    selector_q <= {selector_q[2:0], selector_q[3]};
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            anodes_q     <= dark ? 4'hF : ~selector_q;
            segments_q   <= seg_decoded;
            // Pulse lands on the first cycle of the new frame (selector back at 0001, cnt 0).
            frame_tick_q <= scan.enable && slot_end && (selector_q == SEL_MIN_TENS);
        end
    end

    assign scan.selector   = selector_q;
    assign scan.anodes     = anodes_q;
    assign scan.segments   = segments_q;
    assign scan.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomised and directed checks of display_scan_driver against a frame-level model
// that tracks elapsed enabled cycles and derives slot and position arithmetically.
module tb_display_scan_driver;

    localparam int CLK_DIV = 8;
    localparam int BLANK   = 2;
    localparam int FRAME   = 4 * CLK_DIV;

    logic clk;
    logic reset;
    display_scan_driver_if bus();

    display_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk   (clk),
        .reset (reset),
        .scan  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    logic [3:0] digits [4];

    // Digit mux: returns the digit addressed by the driver's one-hot selector.
    always_comb begin
        bus.time_digit = 4'd0;
        case (bus.selector)
            4'b0001: bus.time_digit = digits[0];
            4'b0010: bus.time_digit = digits[1];
            4'b0100: bus.time_digit = digits[2];
            4'b1000: bus.time_digit = digits[3];
            default: bus.time_digit = 4'd0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int slot_of(input int e);
        return (e / CLK_DIV) % 4;
    endfunction

    function automatic logic [3:0] model_an(input int e, input logic en, input logic lz);
        int pos;
        int slot;
        pos  = e % CLK_DIV;
        slot = slot_of(e);
        if (!en || pos < BLANK || (lz && slot == 3 && digits[slot] == 4'd0))
            return 4'hF;
        return ~(4'b0001 << slot);
    endfunction

    // Model state: number of enabled cycles since reset, plus registered expectations.
    int         e;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_ft;
    logic [3:0] exp_sel;

    assign exp_sel = 4'b0001 << slot_of(e);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e       <= 0;
            exp_an  <= 4'hF;
            exp_seg <= 7'h7F;
            exp_ft  <= 1'b0;
        end else begin
            exp_an  <= model_an(e, bus.enable, bus.lz_blank);
            exp_seg <= seg_of(digits[slot_of(e)]);
            exp_ft  <= bus.enable && (((e + 1) % FRAME) == 0);
            if (bus.enable) e <= e + 1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("selector",   32'(bus.selector),   32'(exp_sel));
            check("anodes",     32'(bus.anodes),     32'(exp_an));
            check("segments",   32'(bus.segments),   32'(exp_seg));
            check("frame_tick", 32'(bus.frame_tick), 32'(exp_ft));
        end
    end

    // Waits for the selector to newly arrive at s (observed with cnt == 0), bounded.
    task automatic wait_sel(input logic [3:0] s);
        int n;
        n = 0;
        while (bus.selector === s && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (bus.selector !== s && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_selector", 32'(bus.selector), 32'(s));
    endtask

    task automatic after_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.lz_blank = 1'b0;
        digits[0] = 4'd1; digits[1] = 4'd2; digits[2] = 4'd3; digits[3] = 4'd4;
        checking = 1'b1;
        #23 reset = 1'b0;

        // Reset release: first slot lights after two blank cycles.
        after_edges(3);
        check("p3_anodes", 32'(bus.anodes), 32'h0E);
        check("p3_segments", 32'(bus.segments), 32'h79);
        after_edges(5);
        check("p8_selector", 32'(bus.selector), 32'h2);
        after_edges(3);
        check("p11_anodes", 32'(bus.anodes), 32'h0D);
        check("p11_segments", 32'(bus.segments), 32'h24);
        after_edges(21);
        check("p32_frame_tick", 32'(bus.frame_tick), 32'h1);
        check("p32_selector", 32'(bus.selector), 32'h1);
        after_edges(1);
        check("p33_frame_tick", 32'(bus.frame_tick), 32'h0);

        // Codes above 9 blank the segments while the anode is still driven.
        @(negedge clk) digits[0] = 4'd12;
        wait_sel(4'b0001);
        after_edges(3);
        check("code12_anodes", 32'(bus.anodes), 32'h0E);
        check("code12_segments", 32'(bus.segments), 32'h7F);

        // Leading-zero suppression of the minutes-tens digit.
        @(negedge clk);
        digits[3] = 4'd0;
        bus.lz_blank = 1'b1;
        wait_sel(4'b1000);
        after_edges(3);
        check("lz_zero_anodes", 32'(bus.anodes), 32'hF);
        @(negedge clk) digits[3] = 4'd5;
        wait_sel(4'b1000);
        after_edges(3);
        check("lz_five_anodes", 32'(bus.anodes), 32'h7);
        check("lz_five_segments", 32'(bus.segments), 32'h12);

        // Freeze at cnt 5 of slot 0100, then resume.
        @(negedge clk) bus.lz_blank = 1'b0;
        wait_sel(4'b0100);
        repeat (5) @(posedge clk);
        @(negedge clk) bus.enable = 1'b0;
        after_edges(1);
        check("freeze_anodes", 32'(bus.anodes), 32'hF);
        after_edges(19);
        check("freeze_selector", 32'(bus.selector), 32'h4);
        @(negedge clk) bus.enable = 1'b1;
        after_edges(1);
        check("resume_anodes", 32'(bus.anodes), 32'hB);
        after_edges(1);
        check("resume_cnt7_selector", 32'(bus.selector), 32'h4);
        after_edges(1);
        check("resume_rotate_selector", 32'(bus.selector), 32'h8);

        // Asynchronous reset mid-slot 0010 at cnt 6.
        wait_sel(4'b0010);
        repeat (6) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_selector", 32'(bus.selector), 32'h1);
        check("async_anodes", 32'(bus.anodes), 32'hF);
        check("async_segments", 32'(bus.segments), 32'h7F);
        check("async_frame_tick", 32'(bus.frame_tick), 32'h0);
        digits[0] = 4'd7;
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        after_edges(3);
        check("restart_anodes", 32'(bus.anodes), 32'hE);
        check("restart_segments", 32'(bus.segments), 32'h78);

        // Randomised phase: digits, enable and lz_blank all wander.
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                int k;
                k = $urandom_range(0, 3);
                if (k == 3 && $urandom_range(0, 1) == 0) digits[k] = 4'd0;
                else digits[k] = 4'($urandom_range(0, 15));
            end
            bus.enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) bus.lz_blank = ~bus.lz_blank;
        end

        @(negedge clk);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Drives the 4-digit multiplexed seven-segment display for the timekeeping datapath.
- Generates the one-hot digit selector consumed by the digit mux, and takes back the 4-bit digit the mux returns.
- Decodes that digit to active-low segments and drives active-low anodes.
- Inserts a dead-time blanking interval at the start of every digit slot to prevent ghosting.

Parameters:
- CLK_DIV, 50000, clk cycles per digit slot; legal range 4..2^20.
- BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off; must be at least 1 and less than CLK_DIV.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  scan enable; low freezes the scan and darkens the display
- lz_blank  input  1  when high, blank tens-of-minutes digit if it is 0
- time_digit  input  4  selected digit returned from the digit mux (combinational path from selector)
- selector  output  4  one-hot digit select to the mux: 0001 = sec units, 0010 = sec tens, 0100 = min units, 1000 = min tens
- anodes  output  4  active-low digit enables; bit i corresponds to selector bit i
- segments  output  7  active-low {g,f,e,d,c,b,a}
- frame_tick  output  1  one-cycle pulse at the start of each full 4-digit frame

Behaviour:
- Reset (asynchronous, effective immediately, including mid-slot):
  - internal slot counter cnt = 0
  - selector = 0001
  - anodes = 1111
  - segments = 7'h7F
  - frame_tick = 0
- Slot counter, each clk with enable = 1:
  - if cnt == CLK_DIV-1: cnt <= 0 and selector rotates left (0001 > 0010 > 0100 > 1000 > 0001).
  - otherwise: cnt <= cnt+1.
- selector is always exactly one-hot. No other value is ever driven.
- Anodes, registered every cycle from current cnt and selector (one-cycle latency):
  - all off (1111) if enable == 0, or cnt < BLANK_CYCLES, or (lz_blank == 1 and selector == 1000 and time_digit == 0).
  - otherwise ~selector.
- Segments, registered every cycle from time_digit (one-cycle latency, aligned with anodes):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex)
  - 10..15 = 7F (all off)
- Latency: selector changes at edge T. Mux output settles combinationally. Segments and anodes reflect the new digit after edge T+1. BLANK_CYCLES >= 1 guarantees anodes never light with a stale segment pattern.
- enable = 0:
  - cnt and selector hold their values.
  - anodes go to 1111 on the next edge.
  - segments keep decoding.
  - frame_tick stays 0.
- Re-enable resumes from the frozen cnt and selector, with no restart of the slot.
- frame_tick:
  - high for exactly one cycle, the cycle immediately after the 1000 > 0001 rotation edge, i.e. coincident with selector == 0001 and cnt == 0.
  - not asserted after reset release.
- Simultaneous events:
  - reset dominates enable.
  - lz_blank evaluated every cycle; a change mid-slot takes effect on the next edge.
- Counter width: ceil(log2(CLK_DIV)) bits. No wrap beyond CLK_DIV-1.

Test Plan (CLK_DIV = 8, BLANK_CYCLES = 2 unless stated):
- Reset release, enable = 1, mux model returning 1,2,3,4 for slots 0..3:
  - selector steps 0001 > 0010 > 0100 > 1000 every 8 cycles.
  - anodes are 1111 for the first 2 registered cycles of each slot, then 1110/1101/1011/0111.
  - segments are 79, 24, 30, 19 respectively.
- Full frame wrap:
  - frame_tick pulses once per 32 cycles, on the cycle selector returns to 0001.
  - no pulse in the first frame after reset.
- Digit codes 10..15 on time_digit: segments = 7F while anodes remain active.
- lz_blank = 1 with min tens = 0: anodes stay 1111 throughout the 1000 slot.
  - With min tens = 5, anodes = 0111 and segments = 12.
- enable dropped at cnt = 5 of slot 0100 for 20 cycles:
  - anodes = 1111 after one edge; selector stays 0100.
  - after re-enable the slot completes in 2 more cycles, then rotates to 1000.
- Reset asserted mid-slot 0010 at cnt = 6, asynchronously between edges:
  - all outputs return to reset values immediately.
  - scan restarts at 0001, cnt = 0.
